mem_axi_data_master: RTL and testbench

Blocking data-side AXI4 master that serves the single memory request the MEM stage drives each cycle (ce/we/sel/addr/data).
- Converts the request into one single-beat AXI read or write.
- Holds busy_o high to stall the pipeline until the transaction completes.
- Presents the returned word on rdata_o for the MEM stage's byte/half extraction.
- Sits between the MEM stage and the top-level AXI crossbar.

---
 rtl/mem_axi_data_master_pkg.sv | 28 ++
 rtl/mem_axi_data_master.sv | 184 ++++++++++++++++++
 tb/tb_mem_axi_data_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_data_master_pkg.sv
// Shared definitions for the data-side AXI master: FSM state encoding, fixed AXI
// burst/size/len encodings for single-word transfers, and the MEM-stage request struct.
package mem_axi_data_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StWrResp,
    StDone,
    StDrain
  } mem_axi_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Request bundle as produced by the MEM stage.
  typedef struct packed {
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_cache_struct;

endpackage

// File: rtl/mem_axi_data_master.sv
// Blocking data-side AXI4 master. Turns the MEM-stage request into one single-beat
// AXI read or write, stalls the pipeline via busy_o until it completes, and returns
// load data on rdata_o.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_*                MEM-stage request (ce/we/sel/addr/data)
//   stall_i, flush_i     later-stage hold, pipeline flush
//   busy_o, rdata_o      MEM stall request, load data (valid in DONE)
//   ar*/r*/aw*/w*/b*     AXI4 master channels
module mem_axi_data_master
  import mem_axi_data_master_pkg::*;
#(
  parameter logic [3:0]  AXI_ID     = 4'd1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_ce,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [3:0]              arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  mem_axi_state_e state_q;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    aw_done, w_done, flushed;

  logic aw_hs, w_hs, flush_seen, in_flight;

  always_comb begin
    aw_hs      = awvalid & awready;
    w_hs       = wvalid & wready;
    flush_seen = flushed | flush_i;
    in_flight  = (state_q == StRdAddr) | (state_q == StRdData) |
                 (state_q == StWr) | (state_q == StWrResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      rdata_o <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      flushed <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      // A flush never aborts the bus transaction; it only redirects completion to DRAIN.
      if (in_flight && flush_i) flushed <= 1'b1;

      unique case (state_q)
        StIdle: begin
          flushed <= 1'b0;
          if (req_ce && req_we && (req_sel == '0)) begin
            // Store with no enabled lanes: complete without touching the bus.
            state_q <= StDone;
          end else if (req_ce && !flush_i) begin
            addr_q <= req_addr;
            data_q <= req_data;
            sel_q  <= req_sel;
            if (req_we) begin
              state_q <= StWr;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state_q <= StRdAddr;
              arvalid <= 1'b1;
            end
          end
        end
        StRdAddr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdData;
          end
        end
        StRdData: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (flush_seen) begin
              state_q <= StDrain;
            end else begin
              rdata_o <= rdata;
              state_q <= StDone;
            end
          end
        end
        StWr: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state_q <= StWrResp;
            bready  <= 1'b1;
          end
        end
        StWrResp: begin
          if (bvalid) begin
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state_q <= flush_seen ? StDrain : StDone;
          end
        end
        StDone: begin
          if (flush_i || !stall_i) state_q <= StIdle;
        end
        StDrain: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = req_ce && (state_q != StDone) && (state_q != StDrain);

  assign arid    = AXI_ID;
  assign araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID;
  assign awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;

  assign wdata = data_q;
  assign wstrb = sel_q;
  assign wlast = 1'b1;

  // Responses are always treated as OKAY; low address bits only select lanes upstream.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp, addr_q[1:0]};

endmodule

// File: tb/tb_mem_axi_data_master.sv
module tb_mem_axi_data_master;
  import mem_axi_data_master_pkg::*;

  logic        clk, rst;
  logic        req_ce, req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_addr, req_data;
  logic        stall_i, flush_i, busy_o;
  logic [31:0] rdata_o;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  mem_axi_data_master dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data), .stall_i(stall_i), .flush_i(flush_i),
    .busy_o(busy_o), .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs: ready/valid asserted after this many waiting cycles.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] r_word = '0;
  int ar_age = 0, r_age = 0, aw_age = 0, w_age = 0, b_age = 0;

  // Handshake bookkeeping and captured channel contents.
  int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, valid_cyc = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [16:0] cap_ar, cap_aw;
  logic [4:0]  cap_w;

  logic [31:0] exp_rdata;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // AXI slave, drives on the falling edge.
  initial begin
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = '0; rresp = '0; rlast = 0; bresp = '0;
    forever begin
      @(negedge clk);
      ar_age  = arvalid ? ar_age + 1 : 0;
      arready = arvalid && (ar_age > ar_dly);
      r_age   = rready ? r_age + 1 : 0;
      rvalid  = rready && (r_age > r_dly);
      rdata   = rvalid ? r_word : 32'h0;
      rlast   = rvalid;
      aw_age  = awvalid ? aw_age + 1 : 0;
      awready = awvalid && (aw_age > aw_dly);
      w_age   = wvalid ? w_age + 1 : 0;
      wready  = wvalid && (w_age > w_dly);
      b_age   = bready ? b_age + 1 : 0;
      bvalid  = bready && (b_age > b_dly);
    end
  end

  // Handshake monitor.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (arvalid || awvalid || wvalid) valid_cyc++;
        if (arvalid && arready) begin
          ar_hs++;
          cap_araddr = araddr;
          cap_ar = {arid, arlen, arsize, arburst};
        end
        if (rvalid && rready) r_hs++;
        if (awvalid && awready) begin
          aw_hs++;
          cap_awaddr = awaddr;
          cap_aw = {awid, awlen, awsize, awburst};
        end
        if (wvalid && wready) begin
          w_hs++;
          cap_wdata = wdata;
          cap_w = {wstrb, wlast};
        end
        if (bvalid && bready) b_hs++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for busy_o to fall, and compare against the transaction model.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data,
                        input logic [31:0] rword, input int ard, input int rd,
                        input int awd, input int wd, input int bd, input int stall_cycles);
    int cyc, exp_lat, ar0, r0, aw0, w0, b0, v0;
    bit issue_rd, issue_wr;
    ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd; r_word = rword;
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs; v0 = valid_cyc;
    cap_araddr = 'x; cap_awaddr = 'x; cap_wdata = 'x; cap_ar = 'x; cap_aw = 'x; cap_w = 'x;

    issue_rd = !we;
    issue_wr = we && (sel != 4'b0000);
    if (!issue_rd && !issue_wr) exp_lat = 1;
    else if (issue_rd) exp_lat = 3 + ard + rd;
    else exp_lat = 3 + ((awd > wd) ? awd : wd) + bd;
    if (issue_rd) exp_rdata = rword;

    req_we = we; req_addr = addr; req_sel = sel; req_data = data; req_ce = 1'b1;
    cyc = 0;
    #1;
    while (busy_o && cyc < 60) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_done"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_state_done"}, 32'(dut.state_q), 32'(StDone));
    chk({tag, "_rdata"}, rdata_o, exp_rdata);
    if (issue_rd) begin
      chk({tag, "_araddr"}, cap_araddr, {addr[31:2], 2'b00});
      chk({tag, "_ar_fields"}, {15'b0, cap_ar}, {15'b0, 4'd1, 8'd0, 3'd2, 2'b01});
    end
    if (issue_wr) begin
      chk({tag, "_awaddr"}, cap_awaddr, {addr[31:2], 2'b00});
      chk({tag, "_aw_fields"}, {15'b0, cap_aw}, {15'b0, 4'd1, 8'd0, 3'd2, 2'b01});
      chk({tag, "_wdata"}, cap_wdata, data);
      chk({tag, "_wstrb_wlast"}, {27'b0, cap_w}, {27'b0, sel, 1'b1});
    end

    stall_i = (stall_cycles > 0);
    if (stall_cycles == 0) req_ce = 1'b0;
    for (int k = 0; k < stall_cycles; k++) begin
      @(negedge clk);
      #1;
      chk({tag, "_stall_rdata"}, rdata_o, exp_rdata);
      chk({tag, "_stall_state"}, 32'(dut.state_q), 32'(StDone));
      chk({tag, "_stall_busy"}, {31'b0, busy_o}, 32'd0);
    end
    stall_i = 1'b0;
    req_ce = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_state_idle"}, 32'(dut.state_q), 32'(StIdle));
    chk({tag, "_ar_count"}, ar_hs - ar0, issue_rd ? 1 : 0);
    chk({tag, "_r_count"}, r_hs - r0, issue_rd ? 1 : 0);
    chk({tag, "_aw_count"}, aw_hs - aw0, issue_wr ? 1 : 0);
    chk({tag, "_w_count"}, w_hs - w0, issue_wr ? 1 : 0);
    chk({tag, "_b_count"}, b_hs - b0, issue_wr ? 1 : 0);
    if (!issue_rd && !issue_wr) chk({tag, "_no_valids"}, valid_cyc - v0, 0);
  endtask

  initial begin
    int n, r0;
    logic we;
    logic [3:0] sel;
    rst = 1'b1; req_ce = 0; req_we = 0; req_sel = '0; req_addr = '0; req_data = '0;
    stall_i = 0; flush_i = 0;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valids", {27'b0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    @(negedge clk);

    // Directed: load, immediate slave.
    do_txn("load", 1'b0, 32'h1C00_0006, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    // Directed: store, W ready before AW, then the reverse.
    do_txn("store_w_first", 1'b1, 32'h0000_0402, 4'b1100, 32'hABCD_ABCD, 32'h0,
           0, 0, 2, 0, 0, 0);
    do_txn("store_aw_first", 1'b1, 32'h0000_0402, 4'b1100, 32'hABCD_ABCD, 32'h0,
           0, 0, 0, 2, 1, 0);
    // Directed: store with no lanes enabled.
    do_txn("store_sel0", 1'b1, 32'h0000_0800, 4'b0000, 32'h1111_2222, 32'h0,
           0, 0, 0, 0, 0, 0);
    // Directed: load held in DONE by a later stage.
    do_txn("load_stall", 1'b0, 32'h0000_1234, 4'b0011, 32'h0, 32'h5A5A_0F0F,
           0, 0, 0, 0, 0, 3);

    // Directed: flush during the read data phase.
    ar_dly = 0; r_dly = 4; r_word = 32'hCAFE_F00D;
    r0 = r_hs;
    req_we = 1'b0; req_addr = 32'h0000_0100; req_sel = 4'b1111; req_ce = 1'b1;
    n = 0;
    #1;
    while (dut.state_q != StRdData && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("flush_reach_rd_data", 32'(dut.state_q), 32'(StRdData));
    flush_i = 1'b1;
    @(negedge clk);
    #1;
    flush_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("flush_state_drain", 32'(dut.state_q), 32'(StDrain));
    chk("flush_rdata_kept", rdata_o, exp_rdata);
    chk("flush_r_count", r_hs - r0, 1);
    req_ce = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_state_idle", 32'(dut.state_q), 32'(StIdle));
    chk("flush_rdata_after", rdata_o, exp_rdata);

    // Directed: reset while a write is waiting on AW/W.
    aw_dly = 6; w_dly = 6; b_dly = 0;
    req_we = 1'b1; req_addr = 32'h0000_0080; req_sel = 4'b1111; req_data = 32'h7777_7777;
    req_ce = 1'b1;
    n = 0;
    #1;
    while (!awvalid && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("rst_wr_awvalid", {31'b0, awvalid}, 32'd1);
    rst = 1'b1;
    req_ce = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wr_valids", {27'b0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("rst_wr_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    do_txn("load_after_rst", 1'b0, 32'h0000_2008, 4'b1111, 32'h0, 32'h1234_5678,
           0, 0, 0, 0, 0, 0);

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      do_txn("rand", we, $urandom, sel, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
